// File: rtl/mc_ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl_fsm_if
//  Purpose  : Bundle of control-unit signals between the multicycle control
//             FSM (master) and the datapath / memory side (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface mc_ctrl_fsm_if #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3
);
    // Inputs to the control unit
    logic [OP_W-1:0]    Op;
    logic               zero;
    logic               mem_ready;
    logic               resume;

    // Datapath controls
    logic               PCWre;
    logic               InsMemRW;
    logic               IRWre;
    logic               ExtSel;
    logic               RegWre;
    logic               WrRegDSrc;
    logic               ALUSrcA;
    logic               ALUSrcB;
    logic               DBDataSrc;
    logic [1:0]         RegDst;
    logic [1:0]         PCSrc;
    logic [ALUOP_W-1:0] ALUOp;

    // Memory strobes and status
    logic               mem_rd_n;
    logic               mem_wr_n;
    logic               halted;
    logic               bus_err;
    logic               illegal_op;
    logic [3:0]         state_o;

    modport master (
        input  Op, zero, mem_ready, resume,
        output PCWre, InsMemRW, IRWre, ExtSel, RegWre, WrRegDSrc,
               ALUSrcA, ALUSrcB, DBDataSrc, RegDst, PCSrc, ALUOp,
               mem_rd_n, mem_wr_n, halted, bus_err, illegal_op, state_o
    );

    modport slave (
        output Op, zero, mem_ready, resume,
        input  PCWre, InsMemRW, IRWre, ExtSel, RegWre, WrRegDSrc,
               ALUSrcA, ALUSrcB, DBDataSrc, RegDst, PCSrc, ALUOp,
               mem_rd_n, mem_wr_n, halted, bus_err, illegal_op, state_o
    );
endinterface
`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl_fsm
//  Purpose  : Multicycle CPU control FSM. Sequences IF/ID/EXE/MEM/WB per
//             opcode, with memory ready/timeout handshake, latching HALT with
//             resume, illegal-opcode flagging and clocked branch resolution.
//             Every output is registered from the next state, so it is stable
//             for the whole state it belongs to; actions tied to leaving ID or
//             EXE_BR therefore appear in the first IF cycle that follows.
//  Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl_fsm #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3,
    parameter int MEM_TO  = 15
) (
    input  logic          CLK,
    input  logic          RST,
    mc_ctrl_fsm_if.master bus
);

    typedef enum logic [3:0] {
        S_INIT    = 4'd0,
        S_IF      = 4'd1,
        S_ID      = 4'd2,
        S_EXE_MEM = 4'd3,
        S_MEM     = 4'd4,
        S_WB_LD   = 4'd5,
        S_EXE_BR  = 4'd6,
        S_EXE_ALU = 4'd7,
        S_WB_ALU  = 4'd8,
        S_HALT    = 4'd9
    } state_t;

    // Opcodes (upper six bits of Op)
    localparam logic [5:0] c_OP_ADD  = 6'b000000;
    localparam logic [5:0] c_OP_SUB  = 6'b000001;
    localparam logic [5:0] c_OP_ADDI = 6'b000010;
    localparam logic [5:0] c_OP_OR   = 6'b010000;
    localparam logic [5:0] c_OP_AND  = 6'b010001;
    localparam logic [5:0] c_OP_ORI  = 6'b010010;
    localparam logic [5:0] c_OP_SLL  = 6'b011000;
    localparam logic [5:0] c_OP_SLT  = 6'b100110;
    localparam logic [5:0] c_OP_SLTU = 6'b100111;
    localparam logic [5:0] c_OP_SW   = 6'b110000;
    localparam logic [5:0] c_OP_LW   = 6'b110001;
    localparam logic [5:0] c_OP_BEQ  = 6'b110100;
    localparam logic [5:0] c_OP_BNE  = 6'b110101;
    localparam logic [5:0] c_OP_J    = 6'b111000;
    localparam logic [5:0] c_OP_JR   = 6'b111001;
    localparam logic [5:0] c_OP_JAL  = 6'b111010;
    localparam logic [5:0] c_OP_HALT = 6'b111111;

    // ALU operation codes (3-bit set, zero-extended onto ALUOp)
    localparam logic [2:0] c_ALU_ADD  = 3'b000;
    localparam logic [2:0] c_ALU_SUB  = 3'b001;
    localparam logic [2:0] c_ALU_SLTU = 3'b010;
    localparam logic [2:0] c_ALU_SLT  = 3'b011;
    localparam logic [2:0] c_ALU_SLL  = 3'b100;
    localparam logic [2:0] c_ALU_OR   = 3'b101;
    localparam logic [2:0] c_ALU_AND  = 3'b110;

    // Timeout counter only needs to reach MEM_TO-1
    localparam int                 c_CNT_W    = (MEM_TO > 1) ? $clog2(MEM_TO) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MEM_TO - 1);

    // State and registered outputs
    state_t             r_state;
    logic [5:0]         r_op_q;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_bus_err;
    logic               r_pcwre, r_insmemrw, r_irwre, r_extsel, r_regwre;
    logic               r_wrregdsrc, r_alusrca, r_alusrcb, r_dbdatasrc;
    logic [1:0]         r_regdst, r_pcsrc;
    logic [ALUOP_W-1:0] r_aluop;
    logic               r_mem_rd_n, r_mem_wr_n, r_halted, r_illegal_op;

    // Decode results
    logic [5:0] w_op;
    logic       w_is_alu, w_is_mem, w_is_br, w_is_j, w_is_jr, w_is_jal;
    logic       w_is_halt, w_is_ill, w_ext, w_srca, w_srcb, w_wb_rt;
    logic [2:0] w_alu_code;

    // Next-state and next-output values
    state_t             w_next;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic               w_bus_err_next, w_taken, w_timeout;
    logic               n_pcwre, n_insmemrw, n_irwre, n_extsel, n_regwre;
    logic               n_wrregdsrc, n_alusrca, n_alusrcb, n_dbdatasrc;
    logic [1:0]         n_regdst, n_pcsrc;
    logic [ALUOP_W-1:0] n_aluop;
    logic               n_mem_rd_n, n_mem_wr_n, n_halted, n_illegal_op;

    // Decode the live opcode while in ID, otherwise the one latched there
    always_comb begin
        w_op       = (r_state == S_ID) ? bus.Op[OP_W-1 -: 6] : r_op_q;
        w_is_alu   = 1'b0;
        w_is_mem   = 1'b0;
        w_is_br    = 1'b0;
        w_is_j     = 1'b0;
        w_is_jr    = 1'b0;
        w_is_jal   = 1'b0;
        w_is_halt  = 1'b0;
        w_ext      = 1'b0;
        w_srca     = 1'b0;
        w_srcb     = 1'b0;
        w_wb_rt    = 1'b0;
        w_alu_code = c_ALU_ADD;
        case (w_op)
            c_OP_ADD:  begin w_is_alu = 1'b1; w_alu_code = c_ALU_ADD;  end
            c_OP_SUB:  begin w_is_alu = 1'b1; w_alu_code = c_ALU_SUB;  end
            c_OP_ADDI: begin
                w_is_alu = 1'b1; w_ext = 1'b1; w_srcb = 1'b1; w_wb_rt = 1'b1;
                w_alu_code = c_ALU_ADD;
            end
            c_OP_OR:   begin w_is_alu = 1'b1; w_alu_code = c_ALU_OR;   end
            c_OP_AND:  begin w_is_alu = 1'b1; w_alu_code = c_ALU_AND;  end
            c_OP_ORI:  begin
                w_is_alu = 1'b1; w_srcb = 1'b1; w_wb_rt = 1'b1;
                w_alu_code = c_ALU_OR;
            end
            c_OP_SLL:  begin w_is_alu = 1'b1; w_srca = 1'b1; w_alu_code = c_ALU_SLL; end
            c_OP_SLT:  begin w_is_alu = 1'b1; w_alu_code = c_ALU_SLT;  end
            c_OP_SLTU: begin w_is_alu = 1'b1; w_alu_code = c_ALU_SLTU; end
            c_OP_SW,
            c_OP_LW:   begin w_is_mem = 1'b1; w_ext = 1'b1; end
            c_OP_BEQ,
            c_OP_BNE:  begin w_is_br = 1'b1; w_ext = 1'b1; end
            c_OP_J:    w_is_j    = 1'b1;
            c_OP_JR:   w_is_jr   = 1'b1;
            c_OP_JAL:  w_is_jal  = 1'b1;
            c_OP_HALT: w_is_halt = 1'b1;
            default:   ;
        endcase
        w_is_ill = ~(w_is_alu | w_is_mem | w_is_br | w_is_j | w_is_jr |
                     w_is_jal | w_is_halt);
    end

    // Next state, timeout counter, sticky error and the outputs of the next state
    always_comb begin
        w_taken        = ((r_op_q == c_OP_BEQ) &  bus.zero) |
                         ((r_op_q == c_OP_BNE) & ~bus.zero);
        w_timeout      = (r_cnt == c_CNT_LAST);
        w_next         = S_INIT;
        w_cnt_next     = r_cnt;
        w_bus_err_next = r_bus_err;

        case (r_state)
            S_INIT:    w_next = S_IF;
            S_IF:      w_next = S_ID;
            S_ID: begin
                if (w_is_alu)       w_next = S_EXE_ALU;
                else if (w_is_mem)  w_next = S_EXE_MEM;
                else if (w_is_br)   w_next = S_EXE_BR;
                else if (w_is_halt) w_next = S_HALT;
                else                w_next = S_IF;
            end
            S_EXE_ALU: w_next = S_WB_ALU;
            S_WB_ALU:  w_next = S_IF;
            S_EXE_MEM: begin
                w_next     = S_MEM;
                w_cnt_next = '0;
            end
            S_MEM: begin
                if (bus.mem_ready) begin
                    w_next = (r_op_q == c_OP_LW) ? S_WB_LD : S_IF;
                end else if (w_timeout) begin
                    w_next         = S_HALT;
                    w_bus_err_next = 1'b1;
                end else begin
                    w_next     = S_MEM;
                    w_cnt_next = r_cnt + c_CNT_W'(1);
                end
            end
            S_WB_LD:   w_next = S_IF;
            S_EXE_BR:  w_next = S_IF;
            S_HALT:    w_next = (bus.resume && !r_bus_err) ? S_IF : S_HALT;
            default:   w_next = S_INIT;
        endcase

        n_pcwre      = 1'b0;
        n_insmemrw   = 1'b0;
        n_irwre      = 1'b0;
        n_extsel     = 1'b0;
        n_regwre     = 1'b0;
        n_wrregdsrc  = 1'b0;
        n_alusrca    = 1'b0;
        n_alusrcb    = 1'b0;
        n_dbdatasrc  = 1'b0;
        n_regdst     = 2'b00;
        n_pcsrc      = 2'b00;
        n_aluop      = '0;
        n_mem_rd_n   = 1'b1;
        n_mem_wr_n   = 1'b1;
        n_halted     = 1'b0;
        n_illegal_op = 1'b0;

        case (w_next)
            S_IF: begin
                n_insmemrw = 1'b1;
                n_irwre    = 1'b1;
                n_pcwre    = 1'b1;
                // Exit actions of ID / EXE_BR land in the first IF cycle
                if (r_state == S_ID) begin
                    if (w_is_j) begin
                        n_pcsrc = 2'b11;
                    end else if (w_is_jr) begin
                        n_pcsrc = 2'b10;
                    end else if (w_is_jal) begin
                        n_pcsrc  = 2'b11;
                        n_regwre = 1'b1;
                    end else if (w_is_ill) begin
                        n_pcwre      = 1'b0;
                        n_illegal_op = 1'b1;
                    end
                end else if (r_state == S_EXE_BR) begin
                    n_pcwre = w_taken;
                    n_pcsrc = w_taken ? 2'b01 : 2'b00;
                end
            end
            S_EXE_ALU: begin
                n_extsel  = w_ext;
                n_alusrca = w_srca;
                n_alusrcb = w_srcb;
                n_aluop   = ALUOP_W'(w_alu_code);
            end
            S_WB_ALU: begin
                n_extsel    = w_ext;
                n_regwre    = 1'b1;
                n_wrregdsrc = 1'b1;
                n_regdst    = w_wb_rt ? 2'b01 : 2'b10;
            end
            S_EXE_MEM: begin
                n_extsel  = w_ext;
                n_alusrcb = 1'b1;
                n_aluop   = ALUOP_W'(c_ALU_ADD);
            end
            S_MEM: begin
                n_extsel   = w_ext;
                n_mem_wr_n = (w_op != c_OP_SW);
                n_mem_rd_n = (w_op != c_OP_LW);
            end
            S_WB_LD: begin
                n_extsel    = w_ext;
                n_regwre    = 1'b1;
                n_wrregdsrc = 1'b1;
                n_dbdatasrc = 1'b1;
                n_regdst    = 2'b01;
            end
            S_EXE_BR: begin
                n_extsel = w_ext;
                n_aluop  = ALUOP_W'(c_ALU_SUB);
            end
            S_HALT:   n_halted = 1'b1;
            default:  ;
        endcase
    end

    // State register and registered outputs; reset aborts any operation
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state      <= S_INIT;
            r_op_q       <= '0;
            r_cnt        <= '0;
            r_bus_err    <= 1'b0;
            r_pcwre      <= 1'b0;
            r_insmemrw   <= 1'b0;
            r_irwre      <= 1'b0;
            r_extsel     <= 1'b0;
            r_regwre     <= 1'b0;
            r_wrregdsrc  <= 1'b0;
            r_alusrca    <= 1'b0;
            r_alusrcb    <= 1'b0;
            r_dbdatasrc  <= 1'b0;
            r_regdst     <= 2'b00;
            r_pcsrc      <= 2'b00;
            r_aluop      <= '0;
            r_mem_rd_n   <= 1'b1;
            r_mem_wr_n   <= 1'b1;
            r_halted     <= 1'b0;
            r_illegal_op <= 1'b0;
        end else begin
            r_state      <= w_next;
            if (r_state == S_ID) begin
                r_op_q <= bus.Op[OP_W-1 -: 6];
            end
            r_cnt        <= w_cnt_next;
            r_bus_err    <= w_bus_err_next;
            r_pcwre      <= n_pcwre;
            r_insmemrw   <= n_insmemrw;
            r_irwre      <= n_irwre;
            r_extsel     <= n_extsel;
            r_regwre     <= n_regwre;
            r_wrregdsrc  <= n_wrregdsrc;
            r_alusrca    <= n_alusrca;
            r_alusrcb    <= n_alusrcb;
            r_dbdatasrc  <= n_dbdatasrc;
            r_regdst     <= n_regdst;
            r_pcsrc      <= n_pcsrc;
            r_aluop      <= n_aluop;
            r_mem_rd_n   <= n_mem_rd_n;
            r_mem_wr_n   <= n_mem_wr_n;
            r_halted     <= n_halted;
            r_illegal_op <= n_illegal_op;
        end
    end

    assign bus.PCWre      = r_pcwre;
    assign bus.InsMemRW   = r_insmemrw;
    assign bus.IRWre      = r_irwre;
    assign bus.ExtSel     = r_extsel;
    assign bus.RegWre     = r_regwre;
    assign bus.WrRegDSrc  = r_wrregdsrc;
    assign bus.ALUSrcA    = r_alusrca;
    assign bus.ALUSrcB    = r_alusrcb;
    assign bus.DBDataSrc  = r_dbdatasrc;
    assign bus.RegDst     = r_regdst;
    assign bus.PCSrc      = r_pcsrc;
    assign bus.ALUOp      = r_aluop;
    assign bus.mem_rd_n   = r_mem_rd_n;
    assign bus.mem_wr_n   = r_mem_wr_n;
    assign bus.halted     = r_halted;
    assign bus.bus_err    = r_bus_err;
    assign bus.illegal_op = r_illegal_op;
    assign bus.state_o    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_ctrl_fsm
//  Purpose  : Directed scoreboard bench for mc_ctrl_fsm. The driver pushes a
//             hand-written expected output word for every cycle; the monitor
//             pops one per falling edge and compares the whole output bundle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl_fsm;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    mc_ctrl_fsm_if #(.OP_W(6), .ALUOP_W(3)) bus ();

    mc_ctrl_fsm #(.OP_W(6), .ALUOP_W(3), .MEM_TO(15)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Expected-word bit fields
    localparam logic [24:0] S_IF  = 25'd1,  S_ID  = 25'd2,  S_EXM = 25'd3;
    localparam logic [24:0] S_MEM = 25'd4,  S_WBL = 25'd5,  S_EXB = 25'd6;
    localparam logic [24:0] S_EXA = 25'd7,  S_WBA = 25'd8,  S_HLT = 25'd9;
    localparam logic [24:0] ILL   = 25'(1) << 4;
    localparam logic [24:0] BERR  = 25'(1) << 5;
    localparam logic [24:0] HLTD  = 25'(1) << 6;
    localparam logic [24:0] WR_N  = 25'(1) << 7;
    localparam logic [24:0] RD_N  = 25'(1) << 8;
    localparam logic [24:0] NS    = RD_N | WR_N;
    localparam logic [24:0] A_SUB = 25'(1) << 9;
    localparam logic [24:0] A_SLL = 25'(4) << 9;
    localparam logic [24:0] P_BR  = 25'(1) << 12;
    localparam logic [24:0] P_J   = 25'(3) << 12;
    localparam logic [24:0] D_RT  = 25'(1) << 14;
    localparam logic [24:0] D_RD  = 25'(2) << 14;
    localparam logic [24:0] DBS   = 25'(1) << 16;
    localparam logic [24:0] SRCB  = 25'(1) << 17;
    localparam logic [24:0] SRCA  = 25'(1) << 18;
    localparam logic [24:0] WRS   = 25'(1) << 19;
    localparam logic [24:0] REGW  = 25'(1) << 20;
    localparam logic [24:0] EXT   = 25'(1) << 21;
    localparam logic [24:0] IRW   = 25'(1) << 22;
    localparam logic [24:0] IMR   = 25'(1) << 23;
    localparam logic [24:0] PCW   = 25'(1) << 24;
    localparam logic [24:0] IFO   = PCW | IMR | IRW | NS | S_IF;

    logic [24:0] exp_q[$];
    string       tag_q[$];
    int          checks = 0;
    int          errors = 0;

    wire [24:0] actual = {bus.PCWre, bus.InsMemRW, bus.IRWre, bus.ExtSel,
                          bus.RegWre, bus.WrRegDSrc, bus.ALUSrcA, bus.ALUSrcB,
                          bus.DBDataSrc, bus.RegDst, bus.PCSrc, bus.ALUOp,
                          bus.mem_rd_n, bus.mem_wr_n, bus.halted, bus.bus_err,
                          bus.illegal_op, bus.state_o};

    // Advance to just after the next rising edge and queue that cycle's expectation
    task automatic cyc(input logic [24:0] v, input string tag);
        @(posedge CLK);
        #1;
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    // Monitor: compare one queued expectation per cycle, away from the edge
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            logic [24:0] e;
            string       t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (actual !== e) begin
                errors++;
                $display("FAIL %s: actual=%07h required=%07h", t, actual, e);
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bus.Op        = '0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        bus.resume    = 1'b0;

        cyc(NS, "reset0");
        cyc(NS, "reset1");
        RST = 1'b1;

        // addi: 1,2,7,8,1
        bus.Op = 6'b000010;
        cyc(IFO,                              "addi IF");
        cyc(S_ID | NS,                        "addi ID");
        cyc(S_EXA | NS | EXT | SRCB,          "addi EXE_ALU");
        cyc(S_WBA | NS | EXT | REGW | WRS | D_RT, "addi WB_ALU");
        cyc(IFO,                              "IF after addi");

        // lw, ready on third MEM cycle
        bus.Op = 6'b110001;
        cyc(S_ID | NS,                        "lw ID");
        cyc(S_EXM | NS | EXT | SRCB,          "lw EXE_MEM");
        cyc(S_MEM | WR_N | EXT,               "lw MEM1");
        cyc(S_MEM | WR_N | EXT,               "lw MEM2");
        cyc(S_MEM | WR_N | EXT,               "lw MEM3");
        bus.mem_ready = 1'b1;
        cyc(S_WBL | NS | EXT | REGW | WRS | DBS | D_RT, "lw WB_LD");
        bus.mem_ready = 1'b0;
        cyc(IFO,                              "IF after lw");

        // beq taken
        bus.Op = 6'b110100; bus.zero = 1'b1;
        cyc(S_ID | NS,                        "beq ID");
        cyc(S_EXB | NS | EXT | A_SUB,         "beq EXE_BR");
        cyc(IFO | P_BR,                       "beq taken IF");

        // bne with zero=1: not taken
        bus.Op = 6'b110101;
        cyc(S_ID | NS,                        "bne ID");
        cyc(S_EXB | NS | EXT | A_SUB,         "bne EXE_BR");
        cyc(S_IF | NS | IMR | IRW,            "bne not taken IF");

        // bne with zero=0: taken
        bus.zero = 1'b0;
        cyc(S_ID | NS,                        "bne2 ID");
        cyc(S_EXB | NS | EXT | A_SUB,         "bne2 EXE_BR");
        cyc(IFO | P_BR,                       "bne taken IF");

        // sll
        bus.Op = 6'b011000;
        cyc(S_ID | NS,                        "sll ID");
        cyc(S_EXA | NS | SRCA | A_SLL,        "sll EXE_ALU");
        cyc(S_WBA | NS | REGW | WRS | D_RD,   "sll WB_ALU");
        cyc(IFO,                              "IF after sll");

        // illegal opcode
        bus.Op = 6'b101010;
        cyc(S_ID | NS,                        "illegal ID");
        cyc(S_IF | NS | IMR | IRW | ILL,      "illegal pulse IF");

        // j
        bus.Op = 6'b111000;
        cyc(S_ID | NS,                        "j ID");
        cyc(IFO | P_J,                        "j IF");

        // jal
        bus.Op = 6'b111010;
        cyc(S_ID | NS,                        "jal ID");
        cyc(IFO | P_J | REGW,                 "jal IF");

        // halt then resume
        bus.Op = 6'b111111;
        cyc(S_ID | NS,                        "halt ID");
        cyc(S_HLT | NS | HLTD,                "halt 1");
        cyc(S_HLT | NS | HLTD,                "halt 2");
        bus.resume = 1'b1;
        cyc(IFO,                              "resume IF");
        bus.resume = 1'b0;

        // reset during lw MEM
        bus.Op = 6'b110001;
        cyc(S_ID | NS,                        "lw2 ID");
        cyc(S_EXM | NS | EXT | SRCB,          "lw2 EXE_MEM");
        cyc(S_MEM | WR_N | EXT,               "lw2 MEM1");
        cyc(NS,                               "reset in lw MEM");
        RST = 1'b0;
        cyc(NS,                               "reset held");
        RST = 1'b1;
        cyc(IFO,                              "IF after reset");

        // sw timeout
        bus.Op = 6'b110000;
        cyc(S_ID | NS,                        "sw ID");
        cyc(S_EXM | NS | EXT | SRCB,          "sw EXE_MEM");
        for (int i = 0; i < 15; i++) begin
            cyc(S_MEM | RD_N | EXT,           "sw MEM wait");
        end
        cyc(S_HLT | NS | HLTD | BERR,         "sw timeout HALT");
        bus.resume = 1'b1;
        cyc(S_HLT | NS | HLTD | BERR,         "halt ignores resume 1");
        cyc(S_HLT | NS | HLTD | BERR,         "halt ignores resume 2");
        bus.resume = 1'b0;
        cyc(NS,                               "reset clears bus_err");
        RST = 1'b0;
        cyc(NS,                               "final reset held");
        RST = 1'b1;
        cyc(IFO,                              "IF after final reset");

        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: actual=%0d pending required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
